// File: rtl/game_timer.sv
`default_nettype none
// ============================================================================
//  Module   : game_timer
//  Brief    : Game timekeeper. Runs the pre-game countdown in WAIT and the
//             BCD min:sec countdown in GAME. Reports pre-countdown completion
//             and timeout to the game FSM. Drives the 4-digit display word.
//  Revision : 1.0  initial release
// ============================================================================
module game_timer #(
    parameter int TICK_DIV   = 100_000_000,  // clk cycles per 1 s tick
    parameter int PRE_SEC    = 3,            // pre-game countdown, 1..9
    parameter int START_MIN  = 4,            // start minutes digit, 0..9
    parameter int START_SECT = 4,            // start tens-of-seconds, 0..5
    parameter int START_SECO = 4             // start ones-of-seconds, 0..9
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-high
    input  logic [2:0]  state,      // INIT=0 WAIT=1 GAME=2 WIN=3 LOSE=4
    output logic        wait_done,  // 1-cycle pulse when pre-countdown hits 0
    output logic        time_up,    // high while in GAME at 0:00
    output logic [15:0] num         // {d3,d2,d1,d0}; 4'd10 shows a dash
);

    // A one-cycle-per-tick divider still needs a 1-bit counter.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] c_PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [3:0]    c_PRE       = 4'(PRE_SEC);
    localparam logic [3:0]    c_MIN       = 4'(START_MIN);
    localparam logic [3:0]    c_SECT      = 4'(START_SECT);
    localparam logic [3:0]    c_SECO      = 4'(START_SECO);
    localparam logic [3:0]    c_DASH      = 4'd10;
    localparam logic [15:0]   c_ALL_DASH  = 16'hAAAA;

    localparam logic [2:0] c_INIT = 3'd0;
    localparam logic [2:0] c_WAIT = 3'd1;
    localparam logic [2:0] c_GAME = 3'd2;
    localparam logic [2:0] c_WIN  = 3'd3;

    logic [2:0]    r_prev_state;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_pre_cnt;
    logic [3:0]    r_min;
    logic [3:0]    r_sect;
    logic [3:0]    r_seco;
    logic          r_wait_done;
    logic          r_time_up;
    logic [15:0]   r_num;

    logic          w_state_chg;
    logic          w_run;
    logic          w_tick;
    logic          w_reload;
    logic          w_at_zero;
    logic [3:0]    w_min_dec;
    logic [3:0]    w_sect_dec;
    logic [3:0]    w_seco_dec;

    // A state change always beats a tick landing in the same cycle, so the
    // tick strobe is suppressed whenever the state input has just moved.
    assign w_state_chg = (state != r_prev_state);
    assign w_run       = (state == c_WAIT) || (state == c_GAME);
    assign w_tick      = w_run && !w_state_chg && (r_presc == c_PRESC_TOP);

    // INIT keeps everything primed; entering WAIT from anywhere rearms a game.
    assign w_reload    = (state == c_INIT) || (w_state_chg && (state == c_WAIT));

    assign w_at_zero   = (r_min == 4'd0) && (r_sect == 4'd0) && (r_seco == 4'd0);

    // BCD borrow chain for one second; holds at 0:00 instead of wrapping.
    always_comb begin
        w_min_dec  = r_min;
        w_sect_dec = r_sect;
        w_seco_dec = r_seco;
        if (!w_at_zero) begin
            if (r_seco != 4'd0) begin
                w_seco_dec = r_seco - 4'd1;
            end else begin
                w_seco_dec = 4'd9;
                if (r_sect != 4'd0) begin
                    w_sect_dec = r_sect - 4'd1;
                end else begin
                    w_sect_dec = 4'd5;
                    w_min_dec  = r_min - 4'd1;
                end
            end
        end
    end

    // Remember last cycle's state so transitions can be detected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_state <= c_INIT;
        end else begin
            r_prev_state <= state;
        end
    end

    // One-second prescaler: runs only in WAIT/GAME, restarts on any transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_state_chg || !w_run || (r_presc == c_PRESC_TOP)) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Pre-game countdown with a single completion pulse on the 1->0 step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_cnt   <= c_PRE;
            r_wait_done <= 1'b0;
        end else begin
            r_wait_done <= 1'b0;
            if (w_reload) begin
                r_pre_cnt <= c_PRE;
            end else if ((state == c_WAIT) && w_tick && (r_pre_cnt != 4'd0)) begin
                r_pre_cnt <= r_pre_cnt - 4'd1;
                if (r_pre_cnt == 4'd1) begin
                    r_wait_done <= 1'b1;
                end
            end
        end
    end

    // Game clock digits: reload when armed, count down once per GAME tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min  <= c_MIN;
            r_sect <= c_SECT;
            r_seco <= c_SECO;
        end else if (w_reload) begin
            r_min  <= c_MIN;
            r_sect <= c_SECT;
            r_seco <= c_SECO;
        end else if ((state == c_GAME) && w_tick) begin
            r_min  <= w_min_dec;
            r_sect <= w_sect_dec;
            r_seco <= w_seco_dec;
        end
    end

    // Registered timeout flag and display word, built from the current
    // counter registers so they trail a state or digit change by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_time_up <= 1'b0;
            r_num     <= c_ALL_DASH;
        end else begin
            r_time_up <= (state == c_GAME) && w_at_zero;
            case (state)
                c_WAIT:         r_num <= {c_DASH, c_DASH, c_DASH, r_pre_cnt};
                c_GAME, c_WIN:  r_num <= {4'd0, r_min, r_sect, r_seco};
                default:        r_num <= c_ALL_DASH;
            endcase
        end
    end

    assign wait_done = r_wait_done;
    assign time_up   = r_time_up;
    assign num       = r_num;

endmodule
`default_nettype wire

// File: tb/tb_game_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_timer
//  Brief    : Directed self-checking bench for game_timer. Two instances:
//             dut_a starts at 4:44, dut_b starts at 0:01 for the timeout case.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_game_timer;

    localparam logic [2:0] c_INIT = 3'd0;
    localparam logic [2:0] c_WAIT = 3'd1;
    localparam logic [2:0] c_GAME = 3'd2;
    localparam logic [2:0] c_WIN  = 3'd3;

    logic        clk;
    logic        rst;
    logic [2:0]  state_a;
    logic [2:0]  state_b;
    logic        wait_done_a;
    logic        time_up_a;
    logic [15:0] num_a;
    logic        wait_done_b;
    logic        time_up_b;
    logic [15:0] num_b;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses_a = 0;

    game_timer #(
        .TICK_DIV   (4),
        .PRE_SEC    (3),
        .START_MIN  (4),
        .START_SECT (4),
        .START_SECO (4)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .state     (state_a),
        .wait_done (wait_done_a),
        .time_up   (time_up_a),
        .num       (num_a)
    );

    game_timer #(
        .TICK_DIV   (4),
        .PRE_SEC    (3),
        .START_MIN  (0),
        .START_SECT (0),
        .START_SECO (1)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .state     (state_b),
        .wait_done (wait_done_b),
        .time_up   (time_up_b),
        .num       (num_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every wait_done pulse seen on dut_a.
    always @(negedge clk) begin
        if (wait_done_a) pulses_a = pulses_a + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        state_a = c_INIT;
        state_b = c_INIT;

        // Reset and idle in INIT.
        step(3);
        chk16("rst_num", num_a, 16'hAAAA);
        rst = 1'b0;
        step(20);
        chk16("init_num", num_a, 16'hAAAA);
        chk1("init_wait_done", wait_done_a, 1'b0);
        chk1("init_time_up", time_up_a, 1'b0);
        chk16("init_num_b", num_b, 16'hAAAA);

        // Pre-game countdown: ticks land 4, 8, 12 cycles after entry.
        state_a = c_WAIT;
        step(2);
        chk16("wait_3", num_a, 16'hAAA3);
        chk1("wait_no_pulse", wait_done_a, 1'b0);
        step(4);
        chk16("wait_2", num_a, 16'hAAA2);
        step(4);
        chk16("wait_1", num_a, 16'hAAA1);
        step(3);
        chk1("wait_pulse_hi", wait_done_a, 1'b1);
        step(1);
        chk1("wait_pulse_lo", wait_done_a, 1'b0);
        chk16("wait_0", num_a, 16'hAAA0);
        step(12);
        chk16("wait_hold_0", num_a, 16'hAAA0);
        chk16("wait_pulse_count", 16'(pulses_a), 16'd1);

        // Game countdown from 4:44; digit k is on display 2+4k cycles in.
        state_a = c_GAME;
        step(2);
        chk16("game_444", num_a, 16'h0444);
        chk1("game_time_up_lo", time_up_a, 1'b0);
        step(4);
        chk16("game_443", num_a, 16'h0443);
        step(12);
        chk16("game_440", num_a, 16'h0440);
        step(4);
        chk16("game_439", num_a, 16'h0439);
        step(156);
        chk16("game_400", num_a, 16'h0400);
        step(4);
        chk16("game_359", num_a, 16'h0359);
        step(408);
        chk16("game_217", num_a, 16'h0217);

        // WIN freezes the display; re-entering WAIT rearms 4:44.
        state_a = c_WIN;
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk16("win_hold", num_a, 16'h0217);
        end
        chk1("win_time_up", time_up_a, 1'b0);
        state_a = c_WAIT;
        step(2);
        chk16("rewait_3", num_a, 16'hAAA3);
        state_a = c_GAME;
        step(1);
        chk16("reload_444", num_a, 16'h0444);

        // Timeout on the 0:01 instance.
        state_b = c_GAME;
        step(1);
        chk16("b_start", num_b, 16'h0001);
        chk1("b_time_up_start", time_up_b, 1'b0);
        step(4);
        chk1("b_time_up_edge", time_up_b, 1'b0);
        step(1);
        chk16("b_zero", num_b, 16'h0000);
        chk1("b_time_up_hi", time_up_b, 1'b1);
        step(12);
        chk16("b_saturate", num_b, 16'h0000);
        chk1("b_time_up_hold", time_up_b, 1'b1);
        state_b = c_WIN;
        step(1);
        chk1("b_win_time_up", time_up_b, 1'b0);
        chk16("b_win_num", num_b, 16'h0000);

        // Asynchronous reset while pre_cnt is 1.
        state_a = c_WAIT;
        step(10);
        chk16("mid_wait_1", num_a, 16'hAAA1);
        #2 rst = 1'b1;
        #1;
        chk16("async_rst_num", num_a, 16'hAAAA);
        chk1("async_rst_wait_done", wait_done_a, 1'b0);
        step(6);
        chk1("rst_no_pulse", wait_done_a, 1'b0);
        chk16("rst_pulse_count", 16'(pulses_a), 16'd1);
        rst = 1'b0;
        step(2);
        chk16("post_rst_3", num_a, 16'hAAA3);
        step(8);
        chk16("post_rst_1", num_a, 16'hAAA1);
        chk16("post_rst_pulse_count", 16'(pulses_a), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
